// File: rtl/imu_pkg.sv
// imu_pkg -- shared constants for the instruction-memory fetch unit.
//   Fault cause codes, the debug-address region nibble base, the default
//   two-region memory map (user program at 0x3000, interrupt handlers at
//   0xF000) and the word-range check shared by fetch and debug decode.
package imu_pkg;

  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_UNMAPPED   = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'b10;

  // Debug address bits [19:16] hold this value plus the region index.
  localparam logic [3:0] DBG_NIB_BASE = 4'h2;

  // Word index width; matches the 16-bit word field of the debug address.
  localparam int IDX_W = 16;

  // Region 0 in the LSBs.
  localparam logic [31:0] DEF_REGION_BASE  = {16'hF000, 16'h3000};
  localparam logic [63:0] DEF_REGION_WORDS = {32'd960, 32'd2048};

  // A word index is inside a region when it is below the region depth.
  function automatic logic idx_in_range(input logic [31:0] idx,
                                        input logic [31:0] words);
    return idx < words;
  endfunction

endpackage

// File: rtl/imu_region_decode.sv
// imu_region_decode -- combinational fetch address decode.
//   i_addr   : fetch byte address
//   o_hit    : address falls in some region (alignment not considered)
//   o_region : index of the lowest matching region
//   o_widx   : word index inside that region, (addr - base) >> 2
//   o_misal  : addr[1:0] != 0
module imu_region_decode
  import imu_pkg::*;
#(
  parameter int                           ADDR_W       = 16,
  parameter int                           REGION_NUM   = 2,
  parameter logic [REGION_NUM*ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [REGION_NUM*32-1:0]     REGION_WORDS = DEF_REGION_WORDS,
  parameter int                           RIDX_W       = 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [RIDX_W-1:0] o_region,
  output logic [IDX_W-1:0]  o_widx,
  output logic              o_misal
);

  logic [31:0] w_addr;
  logic [31:0] w_base;
  logic [31:0] w_off;
  logic        w_unused_off;

  assign w_addr  = 32'(i_addr);
  assign o_misal = (i_addr[1:0] != 2'b00);

  // Walk from the highest region down so the lowest matching region wins.
  // The range test is done on the word offset so base + 4*words never
  // has to be formed.
  always_comb begin
    o_hit    = 1'b0;
    o_region = '0;
    o_widx   = '0;
    w_base   = '0;
    w_off    = '0;
    for (int r = REGION_NUM - 1; r >= 0; r--) begin
      w_base = 32'(REGION_BASE[r*ADDR_W +: ADDR_W]);
      w_off  = w_addr - w_base;
      if ((w_addr >= w_base) && idx_in_range(w_off >> 2, REGION_WORDS[r*32 +: 32])) begin
        o_hit    = 1'b1;
        o_region = RIDX_W'(r);
        o_widx   = w_off[IDX_W+1:2];
      end
    end
  end

  assign w_unused_off = ^{w_off[31:IDX_W+2], w_off[1:0]};

endmodule

// File: rtl/imu_fetch_unit.sv
// imu_fetch_unit -- multi-region instruction memory with a valid/ready
// fetch port, one-cycle memory latency and an in-order response FIFO.
//   clk, rstn                : clock, async active-low reset
//   req_valid/ready/addr     : fetch request handshake
//   resp_valid/ready/data/err: fetch response handshake (data 0 on error)
//   fault_valid/addr/cause   : sticky first-fault register, fault_clr clears
//   dbg_addr/we/din/dout     : debug access, {4'h2+region, word index}
module imu_fetch_unit
  import imu_pkg::*;
#(
  parameter int                           ADDR_W       = 16,
  parameter int                           DATA_W       = 32,
  parameter int                           REGION_NUM   = 2,
  parameter logic [REGION_NUM*ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [REGION_NUM*32-1:0]     REGION_WORDS = DEF_REGION_WORDS,
  parameter int                           FIFO_DEPTH   = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              fault_valid,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [1:0]        fault_cause,
  input  logic              fault_clr,
  input  logic [19:0]       dbg_addr,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_din,
  output logic [DATA_W-1:0] dbg_dout
);

  localparam int RIDX_W = (REGION_NUM > 1) ? $clog2(REGION_NUM) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

  // ---------------- fetch decode ----------------
  logic              w_hit, w_misal, w_fault, w_acc;
  logic [RIDX_W-1:0] w_reg;
  logic [IDX_W-1:0]  w_widx;
  logic [1:0]        w_cause;
  logic              w_unused_widx;

  imu_region_decode #(
    .ADDR_W      (ADDR_W),
    .REGION_NUM  (REGION_NUM),
    .REGION_BASE (REGION_BASE),
    .REGION_WORDS(REGION_WORDS),
    .RIDX_W      (RIDX_W)
  ) u_fetch_dec (
    .i_addr  (req_addr),
    .o_hit   (w_hit),
    .o_region(w_reg),
    .o_widx  (w_widx),
    .o_misal (w_misal)
  );

  assign w_acc         = req_valid && req_ready;
  assign w_fault       = w_misal || !w_hit;
  assign w_cause       = w_misal ? CAUSE_MISALIGNED : CAUSE_UNMAPPED;
  assign w_unused_widx = ^w_widx;

  // ---------------- debug decode ----------------
  logic [REGION_NUM-1:0] w_dbg_hit;
  logic [RIDX_W-1:0]     w_dbg_reg;
  logic [IDX_W-1:0]      w_dbg_widx;

  assign w_dbg_widx = dbg_addr[15:0];

  always_comb begin
    w_dbg_reg = '0;
    for (int r = 0; r < REGION_NUM; r++)
      if (w_dbg_hit[r]) w_dbg_reg = RIDX_W'(r);
  end

  // ---------------- region RAMs ----------------
  logic [REGION_NUM-1:0][DATA_W-1:0] w_fdata;
  logic [REGION_NUM-1:0][DATA_W-1:0] w_ddata;

  for (genvar g = 0; g < REGION_NUM; g++) begin : g_region
    localparam int WORDS = int'(REGION_WORDS[g*32 +: 32]);
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_fd;
    logic [DATA_W-1:0] r_dd;
    logic              w_frd;

    assign w_dbg_hit[g] = (dbg_addr[19:16] == DBG_NIB_BASE + 4'(g)) &&
                          idx_in_range(32'(w_dbg_widx), REGION_WORDS[g*32 +: 32]);
    assign w_frd = w_acc && !w_fault && (w_reg == RIDX_W'(g));

    // Both reads sample the array before the debug write lands, so a
    // fetch hitting the word being written returns the old contents.
    always_ff @(posedge clk) begin
      if (w_frd) r_fd <= r_mem[w_widx[AW-1:0]];
      if (w_dbg_hit[g]) begin
        r_dd <= r_mem[w_dbg_widx[AW-1:0]];
        if (dbg_we) r_mem[w_dbg_widx[AW-1:0]] <= dbg_din;
      end
    end

    assign w_fdata[g] = r_fd;
    assign w_ddata[g] = r_dd;
  end

  // ---------------- S1 + response FIFO ----------------
  logic              r_s1_vld, r_s1_err;
  logic [RIDX_W-1:0] r_s1_reg;
  resp_t             r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wp, r_rp;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_s1_data;
  logic              w_push, w_pop;

  logic              r_fault_vld;
  logic [ADDR_W-1:0] r_fault_addr;
  logic [1:0]        r_fault_cause;
  logic              r_dbg_ok;
  logic [RIDX_W-1:0] r_dbg_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_s1_data = r_s1_err ? '0 : w_fdata[r_s1_reg];
  // Space was reserved when the request was accepted, so S1 always pushes.
  assign w_push    = r_s1_vld;
  assign w_pop     = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_vld      <= 1'b0;
      r_s1_err      <= 1'b0;
      r_s1_reg      <= '0;
      r_wp          <= '0;
      r_rp          <= '0;
      r_cnt         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_fault_vld   <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_cause <= CAUSE_NONE;
      r_dbg_ok      <= 1'b0;
      r_dbg_reg     <= '0;
    end else begin
      r_s1_vld <= w_acc;
      r_s1_err <= w_acc && w_fault;
      r_s1_reg <= w_reg;

      if (w_push) begin
        r_fifo[r_wp] <= '{err: r_s1_err, data: w_s1_data};
        r_wp         <= ptr_inc(r_wp);
      end
      if (w_pop) r_rp <= ptr_inc(r_rp);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

      // A clear in the same cycle frees the register for the new fault.
      if (w_acc && w_fault && (!r_fault_vld || fault_clr)) begin
        r_fault_vld   <= 1'b1;
        r_fault_addr  <= req_addr;
        r_fault_cause <= w_cause;
      end else if (fault_clr) begin
        r_fault_vld   <= 1'b0;
        r_fault_addr  <= '0;
        r_fault_cause <= CAUSE_NONE;
      end

      r_dbg_ok  <= |w_dbg_hit;
      r_dbg_reg <= w_dbg_reg;
    end
  end

  // Outstanding = in S1 + queued; only registered state feeds req_ready.
  assign req_ready   = (32'(r_cnt) + 32'(r_s1_vld)) < 32'(FIFO_DEPTH);
  assign resp_valid  = (r_cnt != '0);
  assign resp_data   = resp_valid ? r_fifo[r_rp].data : '0;
  assign resp_err    = resp_valid ? r_fifo[r_rp].err  : 1'b0;
  assign fault_valid = r_fault_vld;
  assign fault_addr  = r_fault_addr;
  assign fault_cause = r_fault_cause;
  assign dbg_dout    = r_dbg_ok ? w_ddata[r_dbg_reg] : '0;

endmodule

// File: tb/tb_imu_fetch_unit.sv
module tb_imu_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [15:0] req_addr = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        fault_valid;
  logic [15:0] fault_addr;
  logic [1:0]  fault_cause;
  logic        fault_clr = 1'b0;
  logic [19:0] dbg_addr = '0;
  logic        dbg_we = 1'b0;
  logic [31:0] dbg_din = '0;
  logic [31:0] dbg_dout;

  always #5 clk = ~clk;

  imu_fetch_unit dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .fault_valid(fault_valid), .fault_addr(fault_addr),
    .fault_cause(fault_cause), .fault_clr(fault_clr),
    .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_din(dbg_din),
    .dbg_dout(dbg_dout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory map by byte address; responses as a queue of outstanding
  // fetches stamped with the edge after which they become visible.
  int BASE  [2] = '{32'h3000, 32'hF000};
  int WORDS [2] = '{2048, 960};

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          known;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [int];
  int          cyc = 0;
  logic        m_fv = 1'b0;
  logic [15:0] m_fa = '0;
  logic [1:0]  m_fc = '0;
  logic [31:0] m_dbg = '0;
  bit          m_dbg_known = 1'b1;

  function automatic int region_of(input int a);
    for (int r = 0; r < 2; r++)
      if (a >= BASE[r] && a < BASE[r] + 4 * WORDS[r]) return r;
    return -1;
  endfunction

  function automatic int dbg_byte(input logic [19:0] da);
    int r;
    int w;
    r = int'(da[19:16]) - 2;
    w = int'(da[15:0]);
    if (r < 0 || r > 1) return -1;
    if (w >= WORDS[r]) return -1;
    return BASE[r] + 4 * w;
  endfunction

  bit   m_pop, m_acc, m_fe;
  exp_t m_e;
  int   m_ba;
  logic [1:0] m_cause;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      q.delete();
      m_fv = 1'b0; m_fa = '0; m_fc = '0;
      m_dbg = '0; m_dbg_known = 1'b1;
    end else begin
      m_pop = (q.size() > 0) && (cyc >= q[0].stamp + 1) && resp_ready;
      m_acc = req_valid && (q.size() < 3);
      m_fe  = 1'b0;
      m_cause = 2'b00;
      if (m_acc) begin
        m_e.stamp = cyc + 1;
        m_e.known = 1'b1;
        m_e.err   = 1'b0;
        m_e.data  = '0;
        m_ba      = 32'(req_addr);
        if (req_addr[1:0] != 2'b00) begin
          m_fe = 1'b1; m_cause = 2'b10;
        end else if (region_of(m_ba) < 0) begin
          m_fe = 1'b1; m_cause = 2'b01;
        end else begin
          m_e.known = mem_m.exists(m_ba);
          if (m_e.known) m_e.data = mem_m[m_ba];
        end
        m_e.err = m_fe;
      end
      if (m_acc && m_fe) begin
        if (!m_fv || fault_clr) begin
          m_fv = 1'b1; m_fa = req_addr; m_fc = m_cause;
        end
      end else if (fault_clr) begin
        m_fv = 1'b0; m_fa = '0; m_fc = '0;
      end
      m_ba = dbg_byte(dbg_addr);
      if (m_ba < 0) begin
        m_dbg = '0; m_dbg_known = 1'b1;
      end else begin
        m_dbg_known = mem_m.exists(m_ba);
        m_dbg = m_dbg_known ? mem_m[m_ba] : '0;
        if (dbg_we) mem_m[m_ba] = dbg_din;
      end
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(m_e);
      cyc++;
    end
  end

  // ---------------- compare + response log ----------------
  logic [31:0] log_d[$];
  logic        log_e[$];
  int          log_c[$];
  bit          ev;

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("req_ready", req_ready, q.size() < 3);
      ev = (q.size() > 0) && (cyc >= q[0].stamp + 1);
      chk("resp_valid", resp_valid, ev);
      if (ev && q[0].known) begin
        chk("resp_data", resp_data, q[0].data);
        chk("resp_err", resp_err, q[0].err);
      end
      chk("fault_valid", fault_valid, m_fv);
      if (m_fv) begin
        chk("fault_addr", fault_addr, m_fa);
        chk("fault_cause", fault_cause, m_fc);
      end
      if (m_dbg_known) chk("dbg_dout", dbg_dout, m_dbg);
      if (resp_valid && resp_ready) begin
        log_d.push_back(resp_data);
        log_e.push_back(resp_err);
        log_c.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic dbg_write(input logic [3:0] r, input logic [15:0] w, input logic [31:0] d);
    dbg_addr = {4'h2 + r, w};
    dbg_din  = d;
    dbg_we   = 1'b1;
    tick();
    dbg_we   = 1'b0;
  endtask

  // Holds req_valid until the request is taken; leaves it asserted so
  // consecutive calls form a back-to-back burst.
  task automatic fetch(input logic [15:0] a);
    bit rdy;
    bit done;
    done = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      done = rdy;
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL fetch_timeout: addr 0x%0h never accepted", a);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    for (int k = 0; k < 200 && log_d.size() < n; k++) tick();
    if (log_d.size() < n) begin
      n_chk++; n_err++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", log_d.size(), n);
    end
  endtask

  task automatic log_clear();
    log_d.delete(); log_e.delete(); log_c.delete();
  endtask

  int c_first;
  int n_acc;
  logic [31:0] d_at;

  initial begin
    // Reset values while rstn is low.
    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_fault_valid", fault_valid, 1'b0);
    chk("rst_fault_addr", fault_addr, 16'h0);
    chk("rst_fault_cause", fault_cause, 2'b00);
    chk("rst_dbg_dout", dbg_dout, 32'h0);
    tick();
    rstn = 1'b1;
    tick();

    // Preload through the debug port.
    for (int i = 0; i < 8; i++) dbg_write(4'd0, 16'(i), 32'h1000_0000 + i);
    dbg_write(4'd1, 16'd0, 32'hA000_0000);
    dbg_write(4'd1, 16'd959, 32'hA000_03BF);

    // Debug write then read back; bad region and past-end word read 0.
    dbg_write(4'd1, 16'd5, 32'hDEAD_BEEF);
    tick();
    chk("dbg_readback", dbg_dout, 32'hDEAD_BEEF);
    dbg_addr = 20'h40000;
    tick();
    chk("dbg_bad_region", dbg_dout, 32'h0);
    dbg_addr = 20'h303C0;
    tick();
    chk("dbg_past_end", dbg_dout, 32'h0);
    dbg_addr = 20'h20000;
    tick();

    // Back-to-back burst.
    log_clear();
    fetch(16'h3000);
    c_first = cyc;
    fetch(16'h3004);
    fetch(16'h3008);
    idle();
    wait_resp(3);
    chk("burst_d0", log_d[0], 32'h1000_0000);
    chk("burst_d1", log_d[1], 32'h1000_0001);
    chk("burst_d2", log_d[2], 32'h1000_0002);
    chk("burst_latency", 64'(log_c[0]), 64'(c_first + 1));
    chk("burst_c1", 64'(log_c[1]), 64'(log_c[0] + 1));
    chk("burst_c2", 64'(log_c[2]), 64'(log_c[1] + 1));

    // Interrupt region edges and first unmapped word.
    log_clear();
    fetch(16'hF000);
    fetch(16'hFEFC);
    fetch(16'hFF00);
    idle();
    wait_resp(3);
    chk("irq_first", log_d[0], 32'hA000_0000);
    chk("irq_first_err", log_e[0], 1'b0);
    chk("irq_last", log_d[1], 32'hA000_03BF);
    chk("irq_last_err", log_e[1], 1'b0);
    chk("unmapped_err", log_e[2], 1'b1);
    chk("unmapped_data", log_d[2], 32'h0);
    chk("ff00_fault_valid", fault_valid, 1'b1);
    chk("ff00_fault_cause", fault_cause, 2'b01);
    chk("ff00_fault_addr", fault_addr, 16'hFF00);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault_valid", fault_valid, 1'b0);

    // Misaligned beats unmapped ordering; first fault sticks.
    log_clear();
    fetch(16'h3002);
    fetch(16'h2000);
    idle();
    wait_resp(2);
    chk("misal_err", log_e[0], 1'b1);
    chk("unmap2_err", log_e[1], 1'b1);
    chk("sticky_cause", fault_cause, 2'b10);
    chk("sticky_addr", fault_addr, 16'h3002);
    fault_clr = 1'b1;
    fetch(16'h5000);
    fault_clr = 1'b0;
    idle();
    tick(2);
    chk("clr_cap_valid", fault_valid, 1'b1);
    chk("clr_cap_addr", fault_addr, 16'h5000);
    chk("clr_cap_cause", fault_cause, 2'b01);

    // Back-pressure: five requests with the consumer stalled.
    resp_ready = 1'b0;
    log_clear();
    tick(2);
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          fetch(16'h300C + 16'(4 * i));
          n_acc++;
        end
        idle();
      end
      begin
        tick(8);
        chk("stall_accepted", 64'(n_acc), 64'd3);
        chk("stall_req_ready", req_ready, 1'b0);
        chk("stall_head", resp_data, 32'h1000_0003);
        d_at = resp_data;
        tick(3);
        chk("stall_head_hold", resp_data, 32'h1000_0003);
        chk("stall_valid_hold", resp_valid, 1'b1);
        resp_ready = 1'b1;
      end
    join
    wait_resp(5);
    for (int i = 0; i < 5; i++) chk("drain_order", log_d[i], 32'h1000_0003 + i);

    // Reset in the middle of a queued burst.
    resp_ready = 1'b0;
    fetch(16'h3000);
    fetch(16'h3004);
    idle();
    tick(2);
    chk("pre_rst_valid", resp_valid, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_resp_data", resp_data, 32'h0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_fault", fault_valid, 1'b0);
    chk("mid_rst_dbg", dbg_dout, 32'h0);
    tick();
    rstn = 1'b1;
    resp_ready = 1'b1;
    log_clear();
    tick(5);
    chk("no_stale", 64'(log_d.size()), 64'd0);
    fetch(16'h3008);
    idle();
    wait_resp(1);
    chk("post_rst_fetch", log_d[0], 32'h1000_0002);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
